// File: rtl/lsu_dc1_arb_pkg.sv
// Shared types for the LSU DC1 arbiter: packet layout, arbiter state, DMA size codes.
// Pure declarations and small helpers; no logic state.
package lsu_dc1_arb_pkg;

    typedef struct packed {
        logic valid;
        logic dma;
        logic unsign;
        logic store;
        logic load;
        logic word;
        logic half;
        logic by;
    } lsu_pkt_t;

    typedef enum logic {
        RUN   = 1'b0,
        BLOCK = 1'b1
    } lsu_arb_state_t;

    localparam logic [1:0] DMA_SZ_BYTE = 2'b00;
    localparam logic [1:0] DMA_SZ_HALF = 2'b01;
    localparam logic [1:0] DMA_SZ_WORD = 2'b10;

    // DMA requests carry only direction and size; everything else in the packet is zero.
    function automatic lsu_pkt_t dma_pkt(input logic write, input logic [1:0] sz);
        lsu_pkt_t p;
        p       = '0;
        p.valid = 1'b1;
        p.dma   = 1'b1;
        p.store = write;
        p.load  = ~write;
        p.by    = (sz == DMA_SZ_BYTE);
        p.half  = (sz == DMA_SZ_HALF);
        p.word  = (sz == DMA_SZ_WORD);
        return p;
    endfunction

endpackage

// File: rtl/lsu_dc1_arb_if.sv
// Request/grant bundle between the core LSU / DMA requesters and the DC1 arbiter.
// Requesters hold request and payload stable until the matching grant is seen.
interface lsu_dc1_arb_if;
    import lsu_dc1_arb_pkg::*;

    logic        core_req_vld;
    lsu_pkt_t    core_pkt;
    logic [31:0] core_addr;
    logic        core_gnt;
    logic        dma_req_vld;
    logic        dma_write;
    logic [1:0]  dma_sz;
    logic [31:0] dma_addr;
    logic        dma_gnt;

    modport master (
        output core_req_vld, core_pkt, core_addr,
        output dma_req_vld, dma_write, dma_sz, dma_addr,
        input  core_gnt, dma_gnt
    );

    modport slave (
        input  core_req_vld, core_pkt, core_addr,
        input  dma_req_vld, dma_write, dma_sz, dma_addr,
        output core_gnt, dma_gnt
    );
endinterface

// File: rtl/lsu_arb_starve_ctr.sv
// Saturating DMA starvation counter; 1-cycle update, sat is combinational from the count.
// clr beats hold beats inc; hold freezes the count entirely.
module lsu_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic sat
);
    localparam logic [3:0] MAX = 4'(STARVE_MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold && inc && !sat) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign sat = (cnt == MAX);
endmodule

// File: rtl/lsu_dc1_arb.sv
// Core/DMA arbiter into DC1: grants are same-cycle, DC1 packet/addresses register one edge later.
// Freeze blocks all grants and holds DC1; a core fault blocks core issue until flush.
module lsu_dc1_arb
    import lsu_dc1_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    lsu_dc1_arb_if.slave  bus,
    input  logic          freeze,
    input  logic          flush,
    input  logic          fault_dc1,
    output lsu_pkt_t      dc1_pkt,
    output logic [31:0]   dc1_start_addr,
    output logic [31:0]   dc1_end_addr,
    output logic          core_blocked
);
    lsu_arb_state_t state;
    logic           core_elig;
    logic           dma_elig;
    logic           starve_sat;
    lsu_pkt_t       win_pkt;
    logic [31:0]    win_addr;
    logic [31:0]    win_off;

    assign core_elig = bus.core_req_vld && !flush && (state == RUN);
    assign dma_elig  = bus.dma_req_vld;

    // DMA only overrides core once it has lost STARVE_MAX cycles in a row.
    always_comb begin
        bus.core_gnt = 1'b0;
        bus.dma_gnt  = 1'b0;
        if (!rst && !freeze) begin
            bus.dma_gnt  = dma_elig && (!core_elig || starve_sat);
            bus.core_gnt = core_elig && !(dma_elig && starve_sat);
        end
    end

    lsu_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk  (clk),
        .rst  (rst),
        .inc  (bus.dma_req_vld && !bus.dma_gnt && !freeze),
        .clr  (bus.dma_gnt || (!bus.dma_req_vld && !freeze)),
        .hold (freeze),
        .sat  (starve_sat)
    );

    always_comb begin
        win_pkt  = bus.core_pkt;
        win_addr = bus.core_addr;
        if (bus.dma_gnt) begin
            win_pkt  = dma_pkt(bus.dma_write, bus.dma_sz);
            win_addr = bus.dma_addr;
        end else begin
            win_pkt.valid = 1'b1;
            win_pkt.dma   = 1'b0;
        end
        win_off = win_pkt.word ? 32'd3 : (win_pkt.half ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dc1_pkt        <= '0;
            dc1_start_addr <= '0;
            dc1_end_addr   <= '0;
        end else if (!freeze) begin
            if (bus.core_gnt || bus.dma_gnt) begin
                dc1_pkt        <= win_pkt;
                dc1_start_addr <= win_addr;
                dc1_end_addr   <= win_addr + win_off;
            end else begin
                dc1_pkt.valid  <= 1'b0;
            end
        end else if (flush && !dc1_pkt.dma) begin
            // Frozen: only the valid bit of a core packet reacts to flush.
            dc1_pkt.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            core_blocked <= 1'b0;
        end else if (flush) begin
            state        <= RUN;
            core_blocked <= 1'b0;
        end else if (dc1_pkt.valid && !dc1_pkt.dma && fault_dc1) begin
            state        <= BLOCK;
            core_blocked <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lsu_dc1_arb.sv
// Directed scoreboard bench for lsu_dc1_arb: driver queues per-cycle expectations and DC1 payloads,
// a negedge monitor pops and compares them against the DUT.
module tb_lsu_dc1_arb;
    import lsu_dc1_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        fault_dc1 = 1'b0;
    lsu_pkt_t    dc1_pkt;
    logic [31:0] dc1_start_addr;
    logic [31:0] dc1_end_addr;
    logic        core_blocked;

    always #5 clk = ~clk;

    lsu_dc1_arb_if bus();

    lsu_dc1_arb #(.STARVE_MAX(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .freeze         (freeze),
        .flush          (flush),
        .fault_dc1      (fault_dc1),
        .dc1_pkt        (dc1_pkt),
        .dc1_start_addr (dc1_start_addr),
        .dc1_end_addr   (dc1_end_addr),
        .core_blocked   (core_blocked)
    );

    typedef struct { bit cg; bit dg; bit v; bit blk; bit zero; } exp_t;
    typedef struct { lsu_pkt_t pkt; logic [31:0] sa; logic [31:0] ea; } pay_t;

    exp_t        exp_q[$];
    pay_t        pay_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          prev_rst = 1'b1;
    lsu_pkt_t    core_p;
    logic [31:0] core_a;
    logic        dma_w;
    logic [1:0]  dma_s;
    logic [31:0] dma_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] size_off(input bit by, input bit half, input bit word);
        if (word) return 32'd3;
        if (half) return 32'd1;
        if (by)   return 32'd0;
        return 32'd0;
    endfunction

    task automatic step(input bit r, input bit fz, input bit fl, input bit flt,
                        input bit cv, input bit dv,
                        input bit ecg, input bit edg, input bit ev, input bit eblk);
        exp_t e;
        pay_t p;
        @(posedge clk);
        #1;
        rst              = r;
        freeze           = fz;
        flush            = fl;
        fault_dc1        = flt;
        bus.core_req_vld = cv;
        bus.core_pkt     = core_p;
        bus.core_addr    = core_a;
        bus.dma_req_vld  = dv;
        bus.dma_write    = dma_w;
        bus.dma_sz       = dma_s;
        bus.dma_addr     = dma_a;
        e = '{cg: ecg, dg: edg, v: ev, blk: eblk, zero: prev_rst};
        exp_q.push_back(e);
        prev_rst = r;
        if (ecg) begin
            p.pkt       = core_p;
            p.pkt.valid = 1'b1;
            p.pkt.dma   = 1'b0;
            p.sa        = core_a;
            p.ea        = core_a + size_off(core_p.by, core_p.half, core_p.word);
            pay_q.push_back(p);
        end
        if (edg) begin
            p.pkt       = '0;
            p.pkt.valid = 1'b1;
            p.pkt.dma   = 1'b1;
            p.pkt.store = dma_w;
            p.pkt.load  = ~dma_w;
            p.pkt.by    = (dma_s == 2'b00);
            p.pkt.half  = (dma_s == 2'b01);
            p.pkt.word  = (dma_s == 2'b10);
            p.sa        = dma_a;
            p.ea        = dma_a + size_off(p.pkt.by, p.pkt.half, p.pkt.word);
            pay_q.push_back(p);
        end
    endtask

    // Monitor: a grant seen in cycle N means the next DC1 content is the next queued payload.
    initial begin
        exp_t e;
        pay_t cur;
        bit   prev_gnt;
        prev_gnt = 1'b0;
        cur      = '{pkt: '0, sa: '0, ea: '0};
        forever begin
            @(negedge clk);
            if (prev_gnt) begin
                if (pay_q.size() > 0) begin
                    cur = pay_q.pop_front();
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL payload_underflow: got grant with no queued payload at %0t", $time);
                end
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("core_gnt", 32'(bus.core_gnt), 32'(e.cg));
                chk("dma_gnt", 32'(bus.dma_gnt), 32'(e.dg));
                chk("dc1_valid", 32'(dc1_pkt.valid), 32'(e.v));
                chk("core_blocked", 32'(core_blocked), 32'(e.blk));
                if (e.v) begin
                    chk("dc1_pkt", 32'(dc1_pkt), 32'(cur.pkt));
                    chk("dc1_start", dc1_start_addr, cur.sa);
                    chk("dc1_end", dc1_end_addr, cur.ea);
                end
                if (e.zero) begin
                    chk("rst_pkt", 32'(dc1_pkt), 32'd0);
                    chk("rst_start", dc1_start_addr, 32'd0);
                    chk("rst_end", dc1_end_addr, 32'd0);
                end
            end
            prev_gnt = bus.core_gnt || bus.dma_gnt;
        end
    end

    initial begin
        bus.core_req_vld = 1'b0;
        bus.core_pkt     = '0;
        bus.core_addr    = '0;
        bus.dma_req_vld  = 1'b0;
        bus.dma_write    = 1'b0;
        bus.dma_sz       = 2'b00;
        bus.dma_addr     = '0;

        // Reset with everything asserted: no grants, DC1 zero.
        core_p = '0; core_p.word = 1'b1; core_p.load = 1'b1;
        core_p.valid = 1'b0; core_p.dma = 1'b1;  // input .valid/.dma must be ignored
        core_a = 32'h0000_0100;
        dma_w = 1'b0; dma_s = DMA_SZ_WORD; dma_a = 32'h0000_0200;
        //   r  fz fl ft cv dv   cg dg v  blk
        step(1, 1, 1, 0, 1, 1,   0, 0, 0, 0);
        step(1, 1, 1, 0, 1, 1,   0, 0, 0, 0);

        // Starvation: core wins 4 times, DMA forced on the 5th, core again.
        step(0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Address wrap: half at 0xFFFF_FFFE, then word at 0xFFFF_FFFF.
        dma_w = 1'b1; dma_s = DMA_SZ_HALF; dma_a = 32'hFFFF_FFFE;
        step(0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
        dma_w = 1'b0; dma_s = DMA_SZ_WORD; dma_a = 32'hFFFF_FFFF;
        step(0, 0, 0, 0, 0, 1,   0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Core fault blocks core, DMA still served, flush restores.
        core_p = '0; core_p.word = 1'b1; core_p.load = 1'b1; core_a = 32'h0000_0300;
        dma_w = 1'b1; dma_s = DMA_SZ_BYTE; dma_a = 32'h0000_0400;
        step(0, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   0, 1, 0, 1);
        step(0, 0, 1, 0, 1, 0,   0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Freeze for 3 cycles with starve count at 3: DC1 holds, count holds.
        core_p = '0; core_p.word = 1'b1; core_p.store = 1'b1; core_a = 32'h0000_1000;
        dma_w = 1'b0; dma_s = DMA_SZ_BYTE; dma_a = 32'h0000_2000;
        step(0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1,   0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1,   0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 1,   0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Flush with fault and core request; then flush under freeze drops core, keeps DMA.
        core_p = '0; core_p.half = 1'b1; core_p.load = 1'b1; core_p.unsign = 1'b1; core_a = 32'h0000_3000;
        dma_w = 1'b1; dma_s = DMA_SZ_WORD; dma_a = 32'h0000_4000;
        step(0, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0,   1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1,   0, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0,   0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // Reset mid-stream with DC1 valid and starve count 3, alongside freeze and flush.
        core_p = '0; core_p.by = 1'b1; core_p.load = 1'b1; core_a = 32'h0000_5000;
        dma_w = 1'b0; dma_s = DMA_SZ_HALF; dma_a = 32'h0000_6000;
        step(0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(1, 1, 1, 0, 1, 1,   0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1,   0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("pay_q_drained", 32'(pay_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_dc1_arb.md
# lsu_dc1_arb

Arbiter and sequencer for the LSU DC1 stage. Selects between the core LSU request and the DMA request each cycle and registers the winner into DC1 as packet, start address and end address. Those DC1 outputs feed the address-check and DCCM/PIC datapath. It also keeps DMA from being starved, holds DC1 during freeze, and blocks further core issue after a core access fault until a flush.

## Interface
Parameters:
- STARVE_MAX, 4, number of consecutive cycles a valid DMA request may lose before it is forced to win (1..15)

Ports:
- clk  in  1  clock; one clock
- rst  in  1  reset; synchronous, active-high
- core_req_vld  in  1  core LSU request valid
- core_pkt  in  lsu_pkt_t  core packet (by/half/word, store, etc.); .valid and .dma are ignored on input
- core_addr  in  32  core start address
- core_gnt  out  1  core request accepted this cycle
- dma_req_vld  in  1  DMA request valid
- dma_write  in  1  DMA store
- dma_sz  in  2  00 byte, 01 half, 10 word
- dma_addr  in  32  DMA start address
- dma_gnt  out  1  DMA request accepted this cycle
- freeze  in  1  LSU freeze; stalls DC1 and blocks all grants
- flush  in  1  core pipeline flush
- fault_dc1  in  1  access_fault or misaligned_fault for the current DC1 packet, combinational
- dc1_pkt  out  lsu_pkt_t  DC1 packet; .valid is the DC1 valid bit, .dma marks a DMA packet
- dc1_start_addr  out  32  DC1 start address
- dc1_end_addr  out  32  DC1 end address
- core_blocked  out  1  arbiter is in BLOCK state

## Operation
- States: RUN, BLOCK. Reset enters RUN.
- Freeze: no grants are issued, the starve counter does not advance, and all DC1 registers hold.

Grant rules (combinational, same cycle as the request):
- No grant is issued when freeze=1.
- Core is eligible when core_req_vld=1, flush=0 and state=RUN.
- DMA is eligible when dma_req_vld=1.
- If both are eligible, core wins unless starve_cnt==STARVE_MAX, in which case DMA wins.
- Requesters hold request and payload stable until granted. A deasserted request is allowed; it drops the request with no error.

Starve counter:
- Increments when dma_req_vld=1, dma_gnt=0 and freeze=0, saturating at STARVE_MAX.
- Clears on dma_gnt, or when dma_req_vld=0 with freeze=0.

DC1 load (registered on the clock edge after a grant):
- The winner's packet loads with .valid=1. A DMA packet has .dma=1 and .store=dma_write, and dma_sz decodes to by/half/word.
- With no grant and freeze=0, dc1_pkt.valid clears.
- End address = start + {0, 1, 3} for byte/half/word. Arithmetic is 32-bit and wraps modulo 2^32 (0xFFFF_FFFF word gives end 0x0000_0002).

Flush:
- Clears dc1_pkt.valid if the DC1 packet is a core packet; a DMA packet in DC1 is kept.
- Moves the state to RUN.
- Flush is honoured during freeze; DC1 address registers still hold.

Fault:
- dc1_pkt.valid & ~dc1_pkt.dma & fault_dc1 & ~flush moves the state to BLOCK on the next edge.
- In BLOCK, core_gnt=0 and DMA continues normally.
- Flush and fault in the same cycle: flush wins, state goes to RUN.

## Timing
- Grant: 0-cycle, combinational.
- DC1 outputs: 1 cycle after the grant edge.
- Fault to BLOCK: 1 cycle; core_blocked asserts the cycle after fault_dc1.
- Flush to RUN: 1 cycle. A core request can be granted the cycle after flush deasserts.
- Throughput: one grant per non-frozen cycle.
- Reset values: all dc1_pkt fields 0, dc1_start_addr=0, dc1_end_addr=0, state RUN, starve_cnt=0, core_blocked=0. Grants are 0 while rst=1.
- Reset overrides freeze and flush.

## Structure
- veer_types receives the following; lsu_pkt_t is reused unchanged:
  - lsu_arb_state_t enum (RUN, BLOCK)
  - DMA size encoding constants
- Sub-module lsu_arb_starve_ctr: a saturating counter with inc, clr and hold inputs, parameterised by STARVE_MAX, and a sat output.
- The end-address adder stays inline.
- All flops use the standard rvdff family with synchronous active-high reset.

## Test plan
- Simultaneous core and DMA valid for 6 cycles, STARVE_MAX=4:
  - core wins cycles 0–3; DMA wins cycle 4; core wins cycle 5;
  - starve_cnt sequence 1,2,3,4,0,1.
- DMA half write at 0xFFFF_FFFE:
  - dma_gnt the same cycle;
  - next cycle dc1_pkt.dma=1, .half=1, .store=1, dc1_end_addr=0xFFFF_FFFF;
  - a word at 0xFFFF_FFFF gives end 0x0000_0002.
- Core word in DC1 with fault_dc1=1:
  - core_blocked=1 next cycle and core_gnt stays 0 with core_req_vld=1;
  - DMA is still granted;
  - flush pulse, then core_gnt=1 the cycle after.
- freeze=1 for 3 cycles with a core packet at 0x1000 in DC1 and both requesters valid:
  - no grants, DC1 holds at 0x1000, starve_cnt unchanged;
  - on release, core is granted.
- Flush in the same cycle as fault_dc1 and a core request:
  - core_gnt=0, state stays RUN;
  - a core DC1 packet is dropped, a DMA DC1 packet is kept.
- rst asserted mid-stream with DC1 valid and starve_cnt=3: next cycle all outputs are 0 and starve_cnt=0, even with freeze=1.
